bf_tx_fifo: RTL and testbench
=============================

# bf_tx_fifo

Output buffer between the brainfuck core's transmit port and the UART transmitter. Lets the core emit bursts of `.` characters without stalling for every byte at 9600 baud. Core side: write-strobe/busy handshake identical to the one the UART exposes. UART side: AXI-Stream source driving the UART's `input_axis_*` port.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width stored and forwarded.
- `DEPTH_LOG2`, 4, log2 of FIFO depth (16 entries).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low; clears all state immediately.
- `tx_data` in DATA_WIDTH: byte from the core.
- `tx_wr` in 1: core write strobe; one byte per high cycle.
- `tx_busy` out 1: to the core; high when the FIFO is full.
- `m_axis_tdata` out DATA_WIDTH: head byte to the UART.
- `m_axis_tvalid` out 1: head byte valid (FIFO not empty).
- `m_axis_tready` in 1: UART accepts the head byte.
- `level` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky flag; set when a write is dropped.

## Operation
- Storage: circular buffer of 2^DEPTH_LOG2 entries.
- Pointers: `wr_ptr` and `rd_ptr`, each DEPTH_LOG2+1 bits.
  - The MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2^(DEPTH_LOG2+1).
- Flags:
  - empty: `wr_ptr == rd_ptr`.
  - full: low DEPTH_LOG2 bits equal and MSBs differ.
  - `level = wr_ptr - rd_ptr` (unsigned, DEPTH_LOG2+1 bits).
- Push: `tx_wr && !full`.
  - `tx_data` is written at `mem[wr_ptr[DEPTH_LOG2-1:0]]`; `wr_ptr` increments.
- Drop: `tx_wr && full`.
  - Data is discarded and `overflow` is set.
  - `overflow` stays set until reset.
- Pop: `m_axis_tvalid && m_axis_tready`; `rd_ptr` increments.
- Output mapping:
  - `m_axis_tvalid = !empty`.
  - `m_axis_tdata = mem[rd_ptr[DEPTH_LOG2-1:0]]`, a combinational read of the register array.
  - `tx_busy = full`.
- Simultaneous push and pop, non-empty and non-full: both take effect and `level` is unchanged.
- Push while empty: `m_axis_tvalid` cannot be high that cycle, so only the push occurs.
- Push while full with a pop in the same cycle: the push is dropped and `overflow` is set. Full is sampled from the registered pointers before the pop.
- Pop while empty: impossible, since `tvalid` is low; `m_axis_tready` is ignored.
- `m_axis_tdata` and `m_axis_tvalid` stay stable while `tvalid && !tready`, as AXIS requires.

## Timing
- Reset values, applied asynchronously while `rst` is low:
  - `wr_ptr = rd_ptr = 0`, `level = 0`.
  - `m_axis_tvalid = 0`, `tx_busy = 0`, `overflow = 0`.
  - Memory contents are don't-care; `m_axis_tdata` is don't-care while `tvalid = 0`.
- Reset release: the first push is accepted on the first rising edge with `rst` high.
- Write-to-output latency: a byte written on edge N is presented with `m_axis_tvalid = 1` after edge N, so the UART can take it on edge N+1.
- Throughput: one push and one pop per cycle.
- `tx_busy` rises after the edge that makes the FIFO full. It falls after the edge of the first pop from full.
- Reset asserted mid-operation: all queued bytes are lost and the outputs return to their reset values at once. A byte partially shifted out by the UART is the UART's concern.

## Structure
- `brainfuck_constants.sv` gains `TX_FIFO_DEPTH_LOG2` (default 4). The top level passes it as `DEPTH_LOG2`.
- Single module: pointer logic, storage array and flags all live in `bf_tx_fifo`.
- No sub-module is required. If storage is later moved to inferred block RAM, it goes in `bf_tx_fifo_mem`, and that move costs one extra cycle of latency.
- Top-level integration:
  - Core `tx_*` connects to this block.
  - `m_axis_*` connects to UART `input_axis_tdata/tvalid/tready`.
  - `overflow` drives a spare LEDR bit.

## Test plan
- Reset, then 3 writes (0x41, 0x42, 0x43) with `m_axis_tready` = 0 → `level` = 3, `tvalid` = 1, `tdata` = 0x41, `tx_busy` = 0.
- Fill all 16 entries with 0x00..0x0F with `tready` low → `tx_busy` = 1 and `level` = 16 after the 16th edge. A 17th write of 0xFF is dropped, `overflow` = 1, `level` stays 16.
- From full, hold `tready` high for 16 cycles → the bytes 0x00..0x0F emerge in order. Then `tvalid` = 0, `tx_busy` = 0, and `overflow` is still 1.
- Continuous push and pop with `level` at 5 for 100 cycles of incrementing data → `level` stays 5 and the output sequence equals the input sequence delayed by 5 entries. This crosses pointer wrap several times.
- Write 0x55 with `tready` held high → `tvalid` rises one edge after the write and drops one edge after acceptance. `level` goes 0→1→0.
- Assert `rst` low mid-burst at `level` = 7 → `tvalid`, `level`, `tx_busy` and `overflow` go to 0 without waiting for a clock edge. After release, writing 0x99 gives `tdata` = 0x99.

Source files
------------

// File: rtl/bf_tx_fifo_pkg.sv
// Shared constants for the brainfuck transmit path buffer.
// Kept in one place so the top level and the FIFO agree on sizing.
package bf_tx_fifo_pkg;

    localparam int TX_FIFO_DEPTH_LOG2 = 4;
    localparam int TX_DATA_WIDTH      = 8;

endpackage

// File: rtl/bf_tx_fifo.sv
// Transmit FIFO between the core's write-strobe/busy port and the UART's AXI-Stream input.
// Register-array storage with a combinational head read, so a byte is offered the cycle after it is written.
module bf_tx_fifo
    import bf_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_wr,
    output logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  overflow_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;

    // Flags come from the registered pointers only; the extra MSB separates full from empty.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]) &&
                  (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]);
        push_s  = tx_wr && !full_s;
        drop_s  = tx_wr && full_s;
        pop_s   = !empty_s && m_axis_tready;
    end

    // Pointer and sticky overflow state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= tx_data;
        end
    end

    // Output mapping, all derived directly from registered state.
    always_comb begin
        m_axis_tvalid = !empty_s;
        m_axis_tdata  = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
        tx_busy       = full_s;
        level         = wr_ptr_r - rd_ptr_r;
        overflow      = overflow_r;
    end

endmodule

// File: tb/tb_bf_tx_fifo.sv
// Directed self-checking bench for bf_tx_fifo.
// Inputs change on the falling edge; outputs are checked between edges.
module tb_bf_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [4:0] level;
    logic       overflow;

    int checks;
    int fails;

    bf_tx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_wr         (tx_wr),
        .tx_busy       (tx_busy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level         (level),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b0;
        tx_wr         = 1'b0;
        tx_data       = 8'h00;
        m_axis_tready = 1'b0;

        #3;
        check("rst_level",    32'(level), 32'd0);
        check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
        check("rst_busy",     32'(tx_busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        @(negedge clk);
        rst = 1'b1;

        // Three writes held at the head
        tx_wr = 1'b1;
        tx_data = 8'h41; cyc();
        tx_data = 8'h42; cyc();
        tx_data = 8'h43; cyc();
        tx_wr = 1'b0;
        check("w3_level",  32'(level), 32'd3);
        check("w3_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("w3_tdata",  32'(m_axis_tdata), 32'h41);
        check("w3_busy",   32'(tx_busy), 32'd0);

        // Drain them
        m_axis_tready = 1'b1;
        check("d3_b0", 32'(m_axis_tdata), 32'h41); cyc();
        check("d3_b1", 32'(m_axis_tdata), 32'h42); cyc();
        check("d3_b2", 32'(m_axis_tdata), 32'h43); cyc();
        m_axis_tready = 1'b0;
        check("d3_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("d3_level",  32'(level), 32'd0);

        // Fill to capacity
        tx_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(i);
            cyc();
            if (i == 14) begin
                check("f15_busy",  32'(tx_busy), 32'd0);
                check("f15_level", 32'(level), 32'd15);
            end
        end
        check("full_busy",  32'(tx_busy), 32'd1);
        check("full_level", 32'(level), 32'd16);
        check("full_ovf0",  32'(overflow), 32'd0);
        tx_data = 8'hFF;
        cyc();
        check("drop_ovf",   32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd16);
        check("drop_head",  32'(m_axis_tdata), 32'h00);

        // Write while full with a simultaneous pop: write dropped, pop proceeds
        m_axis_tready = 1'b1;
        tx_data = 8'hEE;
        check("dr_b0", 32'(m_axis_tdata), 32'h00);
        cyc();
        tx_wr = 1'b0;
        check("popfull_level", 32'(level), 32'd15);
        check("popfull_busy",  32'(tx_busy), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check("dr_data",   32'(m_axis_tdata), 32'(i));
            check("dr_tvalid", 32'(m_axis_tvalid), 32'd1);
            cyc();
        end
        check("dr_end_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("dr_end_busy",   32'(tx_busy), 32'd0);
        check("dr_end_ovf",    32'(overflow), 32'd1);
        check("dr_end_level",  32'(level), 32'd0);

        // Steady state at level 5 across several pointer wraps
        m_axis_tready = 1'b0;
        tx_wr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tx_data = 8'(k);
            cyc();
        end
        check("ss_level0", 32'(level), 32'd5);
        m_axis_tready = 1'b1;
        for (int k = 5; k < 105; k++) begin
            tx_data = 8'(k);
            check("ss_data", 32'(m_axis_tdata), 32'(k - 5));
            cyc();
            check("ss_level", 32'(level), 32'd5);
        end
        tx_wr = 1'b0;
        for (int k = 100; k < 105; k++) begin
            check("ss_tail", 32'(m_axis_tdata), 32'(k));
            cyc();
        end
        check("ss_empty", 32'(m_axis_tvalid), 32'd0);

        // Single byte with the sink always ready
        tx_wr = 1'b1;
        tx_data = 8'h55;
        check("one_pre_tvalid", 32'(m_axis_tvalid), 32'd0);
        cyc();
        tx_wr = 1'b0;
        check("one_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("one_tdata",  32'(m_axis_tdata), 32'h55);
        check("one_level",  32'(level), 32'd1);
        cyc();
        check("one_post_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("one_post_level",  32'(level), 32'd0);

        // Asynchronous reset in the middle of a burst
        m_axis_tready = 1'b0;
        tx_wr = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tx_data = 8'(8'hA0 + k);
            cyc();
        end
        check("mid_level", 32'(level), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("ar_level",  32'(level), 32'd0);
        check("ar_busy",   32'(tx_busy), 32'd0);
        check("ar_ovf",    32'(overflow), 32'd0);
        tx_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tx_wr = 1'b1;
        tx_data = 8'h99;
        cyc();
        tx_wr = 1'b0;
        check("post_tdata",  32'(m_axis_tdata), 32'h99);
        check("post_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("post_level",  32'(level), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
